// File: rtl/hdmi_packet_pkg.sv
// Shared packet codes, audio group type and helpers for the HDMI data-island scheduler.
package hdmi_packet_pkg;

  localparam logic [7:0] PKT_NULL     = 8'h00;
  localparam logic [7:0] PKT_ACR      = 8'h01;
  localparam logic [7:0] PKT_AUDIO    = 8'h02;
  localparam logic [7:0] PKT_GCP      = 8'h03;
  localparam logic [7:0] PKT_IF_VS    = 8'h81;
  localparam logic [7:0] PKT_IF_AVI   = 8'h82;
  localparam logic [7:0] PKT_IF_SPD   = 8'h83;
  localparam logic [7:0] PKT_IF_AUDIO = 8'h84;
  localparam logic [7:0] PKT_IF_DRM   = 8'h87;
  localparam logic [7:0] PKT_IF_USER  = 8'h7F;

  localparam int unsigned IEC_FRAMES = 192;

  typedef enum logic {
    LayoutTwoCh   = 1'b0,
    LayoutEightCh = 1'b1
  } audio_layout_e;

  // [subpacket][0 = left, 1 = right][24-bit left-justified sample]
  typedef logic [3:0][1:0][23:0] audio_group_t;

  function automatic logic [7:0] frame_advance(input logic [7:0] fc, input logic [7:0] step);
    logic [8:0] sum;
    sum = {1'b0, fc} + {1'b0, step};
    if (sum >= 9'(IEC_FRAMES)) begin
      sum = sum - 9'(IEC_FRAMES);
    end
    return sum[7:0];
  endfunction

endpackage

// File: rtl/hdmi_audio_group_fifo.sv
// Synchronous FIFO of complete audio sample groups; a pop frees space for a same-cycle push.
module hdmi_audio_group_fifo
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  audio_group_t i_push_data,
  input  logic         i_pop,
  output audio_group_t o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] r_wr_ptr;
  logic [PtrW-1:0] r_rd_ptr;
  logic [PtrW:0]   r_count;
  audio_group_t    r_mem [DEPTH];

  logic w_do_push;
  logic w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (PtrW + 1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PtrW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      if (w_do_push && !w_do_pop) begin
        r_count <= r_count + (PtrW + 1)'(1);
      end else if (!w_do_push && w_do_pop) begin
        r_count <= r_count - (PtrW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/hdmi_packet_scheduler.sv
// HDMI data-island scheduler: audio grouping, IEC frame count, ACR/audio/InfoFrame/NULL arbitration.
// Define HDMI_GCP_EN to add the General Control packet (avmute) slot between audio and InfoFrames.
module hdmi_packet_scheduler
  import hdmi_packet_pkg::*;
#(
  parameter int unsigned                  CHANNELS        = 2,
  parameter int unsigned                  AUDIO_BIT_WIDTH = 16,
  parameter int unsigned                  FIFO_DEPTH      = 4,
  parameter int unsigned                  NUM_INFOFRAMES  = 6,
  parameter logic [NUM_INFOFRAMES*8-1:0]  INFOFRAME_TYPES =
      {8'h84, 8'h82, 8'h83, 8'h7F, 8'h81, 8'h87}
) (
  input  logic                                i_clk_pixel,
  input  logic                                i_reset,
  input  logic                                i_video_field_end,
  input  logic                                i_packet_enable,
  input  logic [4:0]                          i_packet_pixel_counter,
  input  logic                                i_acr_request,
  input  logic                                i_sample_valid,
  input  logic [CHANNELS*AUDIO_BIT_WIDTH-1:0] i_sample_word,
  input  logic [NUM_INFOFRAMES-1:0]           i_infoframe_enable,
`ifdef HDMI_GCP_EN
  input  logic                                i_avmute_request,
  output logic                                o_gcp_avmute,
`endif
  output logic [7:0]                          o_packet_type,
  output audio_group_t                        o_audio_word,
  output logic [3:0]                          o_audio_present,
  output logic                                o_audio_layout,
  output logic [7:0]                          o_frame_counter,
  output logic                                o_audio_overflow
);

  if (CHANNELS != 2 && CHANNELS != 8) begin : g_bad_channels
    $error("hdmi_packet_scheduler: CHANNELS must be 2 or 8");
  end
  if (AUDIO_BIT_WIDTH < 16 || AUDIO_BIT_WIDTH > 24) begin : g_bad_width
    $error("hdmi_packet_scheduler: AUDIO_BIT_WIDTH must be 16..24");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
  begin : g_bad_depth
    $error("hdmi_packet_scheduler: FIFO_DEPTH must be a power of two in 2..16");
  end

  localparam audio_layout_e Layout    = (CHANNELS == 8) ? LayoutEightCh : LayoutTwoCh;
  localparam logic [7:0]    FrameStep = (CHANNELS == 8) ? 8'd1 : 8'd4;

  // Channels padded to eight so the layout-1 mapping never indexes past the input.
  logic [23:0] w_chan [8];
  for (genvar c = 0; c < 8; c++) begin : g_chan
    if (c < CHANNELS) begin : g_used
      assign w_chan[c] =
          24'(i_sample_word[c*AUDIO_BIT_WIDTH +: AUDIO_BIT_WIDTH]) << (24 - AUDIO_BIT_WIDTH);
    end else begin : g_unused
      assign w_chan[c] = '0;
    end
  end

  audio_group_t r_asm;
  logic [1:0]   r_asm_idx;
  audio_group_t w_group;
  logic         w_push;

  always_comb begin
    w_group = r_asm;
    w_push  = 1'b0;
    if (i_sample_valid) begin
      if (Layout == LayoutEightCh) begin
        for (int k = 0; k < 4; k++) begin
          w_group[k][0] = w_chan[2*k];
          w_group[k][1] = w_chan[2*k+1];
        end
        w_push = 1'b1;
      end else begin
        w_group[r_asm_idx][0] = w_chan[0];
        w_group[r_asm_idx][1] = w_chan[1];
        w_push = (r_asm_idx == 2'd3);
      end
    end
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_asm     <= '0;
      r_asm_idx <= '0;
    end else if (i_sample_valid) begin
      r_asm <= w_group;
      if (Layout == LayoutTwoCh) begin
        r_asm_idx <= r_asm_idx + 2'd1;
      end
    end
  end

  audio_group_t w_fifo_head;
  logic         w_fifo_full;
  logic         w_fifo_empty;
  logic         w_pop;

  hdmi_audio_group_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk       (i_clk_pixel),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_push_data (w_group),
    .i_pop       (w_pop),
    .o_head      (w_fifo_head),
    .o_full      (w_fifo_full),
    .o_empty     (w_fifo_empty)
  );

  logic                      r_acr_pend;
  logic [NUM_INFOFRAMES-1:0] r_if_pend;
  logic [7:0]                r_packet_type;
  audio_group_t              r_audio_word;
  logic [3:0]                r_audio_present;
  logic [7:0]                r_frame_counter;
  logic                      r_audio_overflow;

  logic                      w_acr_pend;
  logic [NUM_INFOFRAMES-1:0] w_if_ready;
  logic [NUM_INFOFRAMES-1:0] w_if_onehot;
  logic [7:0]                w_if_type;

  assign w_acr_pend  = r_acr_pend | i_acr_request;
  assign w_if_ready  = r_if_pend & i_infoframe_enable;
  // Isolate the lowest set bit: lowest slot index has highest priority.
  assign w_if_onehot = w_if_ready & (~w_if_ready + NUM_INFOFRAMES'(1));

  always_comb begin
    w_if_type = PKT_NULL;
    for (int unsigned i = 0; i < NUM_INFOFRAMES; i++) begin
      if (w_if_onehot[i]) begin
        w_if_type = w_if_type | INFOFRAME_TYPES[(NUM_INFOFRAMES-1-i)*8 +: 8];
      end
    end
  end

`ifdef HDMI_GCP_EN
  logic r_gcp_pend;
  logic r_avmute_prev;
  logic r_gcp_avmute;
  logic w_gcp_sel;
`endif

  logic [7:0]                w_sel_type;
  logic                      w_acr_sel;
  logic [NUM_INFOFRAMES-1:0] w_if_clear;

  always_comb begin
    w_sel_type = PKT_NULL;
    w_acr_sel  = 1'b0;
    w_pop      = 1'b0;
    w_if_clear = '0;
`ifdef HDMI_GCP_EN
    w_gcp_sel  = 1'b0;
`endif
    if (i_packet_enable) begin
      if (w_acr_pend) begin
        w_sel_type = PKT_ACR;
        w_acr_sel  = 1'b1;
      end else if (!w_fifo_empty) begin
        w_sel_type = PKT_AUDIO;
        w_pop      = 1'b1;
`ifdef HDMI_GCP_EN
      end else if (r_gcp_pend) begin
        w_sel_type = PKT_GCP;
        w_gcp_sel  = 1'b1;
`endif
      end else if (|w_if_ready) begin
        w_sel_type = w_if_type;
        w_if_clear = w_if_onehot;
      end
    end
  end

  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_acr_pend       <= 1'b0;
      r_if_pend        <= '1;
      r_packet_type    <= PKT_NULL;
      r_audio_word     <= '0;
      r_audio_present  <= '0;
      r_frame_counter  <= '0;
      r_audio_overflow <= 1'b0;
    end else begin
      if (w_acr_sel) begin
        r_acr_pend <= 1'b0;
      end else if (i_acr_request) begin
        r_acr_pend <= 1'b1;
      end
      // Field end re-arms every slot except the one chosen this cycle.
      if (i_video_field_end) begin
        r_if_pend <= ~w_if_clear;
      end else begin
        r_if_pend <= r_if_pend & ~w_if_clear;
      end
      if (i_packet_enable) begin
        r_packet_type <= w_sel_type;
      end
      if (w_pop) begin
        r_audio_word    <= w_fifo_head;
        r_audio_present <= 4'b1111;
      end
      if (i_packet_pixel_counter == 5'd31 && r_packet_type == PKT_AUDIO) begin
        r_frame_counter <= frame_advance(r_frame_counter, FrameStep);
      end
      if (w_push && w_fifo_full && !w_pop) begin
        r_audio_overflow <= 1'b1;
      end
    end
  end

`ifdef HDMI_GCP_EN
  always_ff @(posedge i_clk_pixel) begin
    if (i_reset) begin
      r_gcp_pend    <= 1'b0;
      r_avmute_prev <= 1'b0;
      r_gcp_avmute  <= 1'b0;
    end else begin
      r_avmute_prev <= i_avmute_request;
      if (i_video_field_end || (i_avmute_request != r_avmute_prev)) begin
        r_gcp_pend <= ~w_gcp_sel | i_avmute_request != r_avmute_prev;
      end else if (w_gcp_sel) begin
        r_gcp_pend <= 1'b0;
      end
      if (w_gcp_sel) begin
        r_gcp_avmute <= i_avmute_request;
      end
    end
  end

  assign o_gcp_avmute = r_gcp_avmute;
`endif

  assign o_packet_type    = r_packet_type;
  assign o_audio_word     = r_audio_word;
  assign o_audio_present  = r_audio_present;
  assign o_audio_layout   = Layout;
  assign o_frame_counter  = r_frame_counter;
  assign o_audio_overflow = r_audio_overflow;

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// Directed bench for hdmi_packet_scheduler (2 channels, 16-bit, depth 4) with a queue-based model.
module tb_hdmi_packet_scheduler;
  import hdmi_packet_pkg::*;

  localparam int unsigned NIF   = 6;
  localparam int unsigned DEPTH = 4;

  logic           clk = 1'b0;
  logic           reset;
  logic           field_end;
  logic           packet_enable;
  logic [4:0]     pixel_counter;
  logic           acr_request;
  logic           sample_valid;
  logic [31:0]    sample_word;
  logic [NIF-1:0] if_enable;
  logic [7:0]     packet_type;
  audio_group_t   audio_word;
  logic [3:0]     audio_present;
  logic           audio_layout;
  logic [7:0]     frame_counter;
  logic           audio_overflow;

  always #5 clk = ~clk;

  hdmi_packet_scheduler dut (
    .i_clk_pixel            (clk),
    .i_reset                (reset),
    .i_video_field_end      (field_end),
    .i_packet_enable        (packet_enable),
    .i_packet_pixel_counter (pixel_counter),
    .i_acr_request          (acr_request),
    .i_sample_valid         (sample_valid),
    .i_sample_word          (sample_word),
    .i_infoframe_enable     (if_enable),
    .o_packet_type          (packet_type),
    .o_audio_word           (audio_word),
    .o_audio_present        (audio_present),
    .o_audio_layout         (audio_layout),
    .o_frame_counter        (frame_counter),
    .o_audio_overflow       (audio_overflow)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: queues of frames and groups, pending flags, plain modular arithmetic.
  logic [7:0]   if_types [NIF] = '{8'h84, 8'h82, 8'h83, 8'h7F, 8'h81, 8'h87};
  logic [31:0]  m_frames [$];
  audio_group_t m_fifo [$];
  bit           m_acr;
  bit [NIF-1:0] m_ifp;
  logic [7:0]   m_type;
  logic [7:0]   m_fc;
  audio_group_t m_word;
  logic [3:0]   m_pres;
  bit           m_ovf;
  bit           m_valid = 1'b0;

  task automatic model_step();
    int chosen;
    bit acr;
    logic [7:0] old_type;
    audio_group_t g;
    if (reset) begin
      m_frames.delete();
      m_fifo.delete();
      m_acr = 0; m_ifp = '1; m_type = 8'h00; m_fc = 8'h00;
      m_word = '0; m_pres = 4'h0; m_ovf = 0; m_valid = 1;
      return;
    end
    old_type = m_type;
    chosen = -1;
    acr = m_acr | acr_request;
    if (packet_enable) begin
      if (acr) begin
        m_type = 8'h01;
        acr = 0;
      end else if (m_fifo.size() > 0) begin
        m_word = m_fifo.pop_front();
        m_pres = 4'hF;
        m_type = 8'h02;
      end else begin
        for (int i = 0; i < NIF; i++)
          if (chosen < 0 && m_ifp[i] && if_enable[i]) chosen = i;
        if (chosen >= 0) begin
          m_type = if_types[chosen];
          m_ifp[chosen] = 0;
        end else begin
          m_type = 8'h00;
        end
      end
    end
    m_acr = acr;
    if (field_end)
      for (int i = 0; i < NIF; i++) if (i != chosen) m_ifp[i] = 1;
    if (sample_valid) begin
      m_frames.push_back(sample_word);
      if (m_frames.size() == 4) begin
        for (int k = 0; k < 4; k++) begin
          g[k][0] = {m_frames[k][15:0], 8'h00};
          g[k][1] = {m_frames[k][31:16], 8'h00};
        end
        m_frames.delete();
        if (m_fifo.size() < DEPTH) m_fifo.push_back(g);
        else m_ovf = 1;
      end
    end
    if (pixel_counter == 5'd31 && old_type == 8'h02) m_fc = 8'((int'(m_fc) + 4) % 192);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("packet_type", 192'(packet_type), 192'(m_type));
      check("audio_word", 192'(audio_word), 192'(m_word));
      check("audio_present", 192'(audio_present), 192'(m_pres));
      check("frame_counter", 192'(frame_counter), 192'(m_fc));
      check("audio_overflow", 192'(audio_overflow), 192'(m_ovf));
      check("audio_layout", 192'(audio_layout), 192'(1'b0));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic send_sample(input logic [15:0] l, input logic [15:0] r);
    sample_valid = 1'b1;
    sample_word  = {r, l};
    tick();
    sample_valid = 1'b0;
    sample_word  = '0;
  endtask

  task automatic strobe();
    packet_enable = 1'b1;
    tick();
    packet_enable = 1'b0;
  endtask

  logic [7:0] exp_seq [7] = '{8'h84, 8'h82, 8'h83, 8'h7F, 8'h81, 8'h87, 8'h00};

  initial begin
    reset = 1'b1; field_end = 0; packet_enable = 0; pixel_counter = '0;
    acr_request = 0; sample_valid = 0; sample_word = '0; if_enable = '1;
    tick();
    tick();
    reset = 1'b0;
    check("reset_type", 192'(packet_type), 192'(8'h00));
    check("reset_word", 192'(audio_word), 192'(0));
    check("reset_fc", 192'(frame_counter), 192'(8'd0));

    // InfoFrame round after reset.
    for (int i = 0; i < 7; i++) begin
      strobe();
      check("if_sequence", 192'(packet_type), 192'(exp_seq[i]));
    end

    // One layout-0 group.
    for (int k = 0; k < 4; k++) send_sample(16'h1234 + 16'(k), 16'h5670 + 16'(k));
    strobe();
    check("audio_type", 192'(packet_type), 192'(8'h02));
    check("audio_w00", 192'(audio_word[0][0]), 192'(24'h123400));
    check("audio_w30", 192'(audio_word[3][0]), 192'(24'h123700));
    check("audio_w21", 192'(audio_word[2][1]), 192'(24'h567200));
    check("audio_present_lit", 192'(audio_present), 192'(4'hF));

    // ACR coincident with the strobe beats a queued group.
    for (int k = 0; k < 4; k++) send_sample(16'h2000 + 16'(k), 16'h0);
    packet_enable = 1'b1; acr_request = 1'b1;
    tick();
    packet_enable = 1'b0; acr_request = 1'b0;
    check("acr_type", 192'(packet_type), 192'(8'h01));
    strobe();
    check("after_acr_type", 192'(packet_type), 192'(8'h02));
    check("after_acr_w10", 192'(audio_word[1][0]), 192'(24'h200100));

    // 49 audio packets advance the IEC frame counter modulo 192.
    for (int i = 0; i < 49; i++) begin
      for (int k = 0; k < 4; k++) send_sample(16'(i * 4 + k), 16'hFFFF);
      strobe();
      pixel_counter = 5'd31;
      tick();
      pixel_counter = 5'd0;
      if (i == 46) check("fc_188", 192'(frame_counter), 192'(8'd188));
      if (i == 47) check("fc_wrap", 192'(frame_counter), 192'(8'd0));
    end
    check("fc_final", 192'(frame_counter), 192'(8'd4));

    // Overflow: five groups into a four-deep FIFO.
    do_reset();
    for (int g = 1; g <= 5; g++)
      for (int k = 0; k < 4; k++) send_sample(16'(g * 256 + k), 16'(g));
    check("overflow_set", 192'(audio_overflow), 192'(1'b1));
    for (int g = 1; g <= 4; g++) begin
      strobe();
      check("ovf_pop_type", 192'(packet_type), 192'(8'h02));
      check("ovf_pop_group", 192'(audio_word[0][0]), 192'(24'(g) << 16));
    end
    strobe();
    check("ovf_drained", 192'(packet_type), 192'(8'h84));

    // Reset mid-group discards the partial group without flagging overflow.
    do_reset();
    send_sample(16'hDEAD, 16'hBEEF);
    send_sample(16'hDEAD, 16'hBEEF);
    do_reset();
    for (int k = 0; k < 4; k++) send_sample(16'h4000 + 16'(k), 16'h0);
    strobe();
    check("midreset_type", 192'(packet_type), 192'(8'h02));
    check("midreset_w00", 192'(audio_word[0][0]), 192'(24'h400000));
    check("midreset_w30", 192'(audio_word[3][0]), 192'(24'h400300));
    check("midreset_ovf", 192'(audio_overflow), 192'(1'b0));
    strobe();
    check("midreset_next", 192'(packet_type), 192'(8'h84));

    // Slot mask and field-end re-arm.
    if_enable = 6'b101010;
    strobe(); check("mask_1", 192'(packet_type), 192'(8'h82));
    strobe(); check("mask_3", 192'(packet_type), 192'(8'h7F));
    strobe(); check("mask_5", 192'(packet_type), 192'(8'h87));
    strobe(); check("mask_none", 192'(packet_type), 192'(8'h00));
    field_end = 1'b1;
    strobe();
    field_end = 1'b0;
    check("fe_coincident", 192'(packet_type), 192'(8'h00));
    strobe(); check("fe_rearm", 192'(packet_type), 192'(8'h82));
    if_enable = '1;
    strobe(); check("fe_slot0", 192'(packet_type), 192'(8'h84));
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
